// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack for the CPU front end.
// One action per cycle, by priority: reset > ret > call > load > branch > enable > hold.
module pc_stack #(
    parameter int unsigned             WIDTH        = 8,
    parameter int unsigned             DEPTH        = 4,
    parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
    localparam int unsigned            CW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic             err_clear,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc_out,
    output logic [CW-1:0]    depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BRANCH,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_e;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    op_e              op;
    logic             push;
    logic             pop;
    logic             ovf_event;
    logic             unf_event;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] pc_next_seq;

    assign stack_full  = (depth == CW'(DEPTH));
    assign stack_empty = (depth == '0);

    // NOTE: every signal driven here gets a default first, so no path through the block leaves a latch.
    always_comb begin
        op = OP_HOLD;
        if (ret)         op = OP_RET;
        else if (call)   op = OP_CALL;
        else if (load)   op = OP_LOAD;
        else if (branch) op = OP_BRANCH;
        else if (enable) op = OP_INC;
    end

    assign push        = (op == OP_CALL) && !stack_full;
    assign pop         = (op == OP_RET)  && !stack_empty;
    assign ovf_event   = (op == OP_CALL) &&  stack_full;
    assign unf_event   = (op == OP_RET)  &&  stack_empty;
    assign wr_idx      = IW'(depth);
    assign rd_idx      = IW'(depth - CW'(1));
    assign pc_next_seq = pc_out + WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= RESET_VECTOR;
            depth  <= '0;
        end else begin
            case (op)
                OP_RET: begin
                    if (pop) begin
                        pc_out <= stack_mem[rd_idx];
                        depth  <= depth - CW'(1);
                    end
                end
                OP_CALL: begin
                    if (push) begin
                        pc_out <= target;
                        depth  <= depth + CW'(1);
                    end
                end
                OP_LOAD:   pc_out <= target;
                // Same-width addition wraps mod 2^WIDTH, which is exactly the signed displacement.
                OP_BRANCH: pc_out <= pc_out + offset;
                OP_INC:    pc_out <= pc_next_seq;
                default:   ;
            endcase
        end
    end

    // NOTE: the stack RAM has no reset; entries above depth are never read, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_mem[wr_idx] <= pc_next_seq;
        end
    end

    // A new error event outranks err_clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (ovf_event)      overflow_err  <= 1'b1;
            else if (err_clear) overflow_err  <= 1'b0;

            if (unf_event)      underflow_err <= 1'b1;
            else if (err_clear) underflow_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, then random stimulus
// compared against a queue-based reference model.
module tb_pc_stack;

    localparam int W = 8;
    localparam int D = 4;
    localparam logic [W-1:0] RV = 8'h00;

    localparam logic [6:0] C_RST = 7'b1000000;
    localparam logic [6:0] C_EN  = 7'b0100000;
    localparam logic [6:0] C_LD  = 7'b0010000;
    localparam logic [6:0] C_BR  = 7'b0001000;
    localparam logic [6:0] C_CL  = 7'b0000100;
    localparam logic [6:0] C_RT  = 7'b0000010;
    localparam logic [6:0] C_EC  = 7'b0000001;
    localparam logic [6:0] C_NO  = 7'b0000000;

    typedef struct {
        logic [6:0] ctl;
        logic [7:0] tgt;
        logic [7:0] off;
        logic [7:0] pc;
        logic [2:0] dep;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, enable, load, branch, call, ret, err_clear;
    logic [W-1:0] target, offset;
    logic [W-1:0] pc_out;
    logic [2:0]   depth;
    logic         stack_full, stack_empty, overflow_err, underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .branch       (branch),
        .call         (call),
        .ret          (ret),
        .err_clear    (err_clear),
        .target       (target),
        .offset       (offset),
        .pc_out       (pc_out),
        .depth        (depth),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [6:0] ctl, input logic [7:0] tgt, input logic [7:0] off,
                               input logic [7:0] pc, input logic [2:0] dep,
                               input logic ovf, input logic unf);
        vec_t r;
        r.ctl = ctl; r.tgt = tgt; r.off = off; r.pc = pc; r.dep = dep; r.ovf = ovf; r.unf = unf;
        return r;
    endfunction

    task automatic drive(input logic [6:0] ctl, input logic [7:0] tgt, input logic [7:0] off);
        @(negedge clk);
        {reset, enable, load, branch, call, ret, err_clear} = ctl;
        target = tgt;
        offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] pc, input logic [2:0] dep,
                                 input logic ovf, input logic unf);
        check({tag, ".pc"},    32'(pc_out), 32'(pc));
        check({tag, ".depth"}, 32'(depth),  32'(dep));
        check({tag, ".flags"}, {28'd0, stack_full, stack_empty, overflow_err, underflow_err},
              {28'd0, dep == 3'(D), dep == 3'd0, ovf, unf});
    endtask

    // Reference model: a plain queue of return addresses plus PC and flags.
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf;

    task automatic model_step(input logic [6:0] ctl, input logic [7:0] tgt, input logic [7:0] off);
        logic r, e, l, b, c, t, ec;
        logic ev_o, ev_u;
        {r, e, l, b, c, t, ec} = ctl;
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (r) begin
            m_pc = RV;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (t) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else ev_u = 1'b1;
        end else if (c) begin
            if (m_stk.size() < D) begin
                m_stk.push_back(8'((int'(m_pc) + 1) % 256));
                m_pc = tgt;
            end else ev_o = 1'b1;
        end else if (l) begin
            m_pc = tgt;
        end else if (b) begin
            m_pc = 8'((int'(m_pc) + int'($signed(off)) + 256) % 256);
        end else if (e) begin
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end
        m_ovf = ev_o ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_unf = ev_u ? 1'b1 : (ec ? 1'b0 : m_unf);
    endtask

    vec_t vecs[$];

    initial begin
        {reset, enable, load, branch, call, ret, err_clear} = '0;
        target = '0;
        offset = '0;

        // Directed table: each row is one clock of stimulus and the state expected after it.
        vecs.push_back(v(C_RST,       8'h00, 8'h00, 8'h00, 3'd0, 0, 0));
        vecs.push_back(v(C_EN,        8'h00, 8'h00, 8'h01, 3'd0, 0, 0));
        vecs.push_back(v(C_EN,        8'h00, 8'h00, 8'h02, 3'd0, 0, 0));
        vecs.push_back(v(C_EN,        8'h00, 8'h00, 8'h03, 3'd0, 0, 0));
        vecs.push_back(v(C_NO,        8'h00, 8'h00, 8'h03, 3'd0, 0, 0));
        vecs.push_back(v(C_NO,        8'h00, 8'h00, 8'h03, 3'd0, 0, 0));
        vecs.push_back(v(C_LD|C_EN,   8'h20, 8'h00, 8'h20, 3'd0, 0, 0));
        vecs.push_back(v(C_BR|C_EN,   8'h00, 8'hF0, 8'h10, 3'd0, 0, 0));
        vecs.push_back(v(C_BR,        8'h00, 8'h05, 8'h15, 3'd0, 0, 0));
        vecs.push_back(v(C_LD,        8'hFF, 8'h00, 8'hFF, 3'd0, 0, 0));
        vecs.push_back(v(C_EN,        8'h00, 8'h00, 8'h00, 3'd0, 0, 0));
        vecs.push_back(v(C_LD,        8'h10, 8'h00, 8'h10, 3'd0, 0, 0));
        vecs.push_back(v(C_CL,        8'h40, 8'h00, 8'h40, 3'd1, 0, 0));
        vecs.push_back(v(C_CL,        8'h80, 8'h00, 8'h80, 3'd2, 0, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h41, 3'd1, 0, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h11, 3'd0, 0, 0));
        vecs.push_back(v(C_CL,        8'h50, 8'h00, 8'h50, 3'd1, 0, 0));
        vecs.push_back(v(C_CL,        8'h60, 8'h00, 8'h60, 3'd2, 0, 0));
        vecs.push_back(v(C_CL,        8'h70, 8'h00, 8'h70, 3'd3, 0, 0));
        vecs.push_back(v(C_CL,        8'h80, 8'h00, 8'h80, 3'd4, 0, 0));
        vecs.push_back(v(C_CL,        8'h90, 8'h00, 8'h80, 3'd4, 1, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h71, 3'd3, 1, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h61, 3'd2, 1, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h51, 3'd1, 1, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h12, 3'd0, 1, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h12, 3'd0, 1, 1));
        vecs.push_back(v(C_EC,        8'h00, 8'h00, 8'h12, 3'd0, 0, 0));
        vecs.push_back(v(C_CL,        8'h20, 8'h00, 8'h20, 3'd1, 0, 0));
        vecs.push_back(v(C_CL|C_RT,   8'h99, 8'h00, 8'h13, 3'd0, 0, 0));
        vecs.push_back(v(C_RT|C_EC,   8'h00, 8'h00, 8'h13, 3'd0, 0, 1));
        vecs.push_back(v(C_CL,        8'hA0, 8'h00, 8'hA0, 3'd1, 0, 1));
        vecs.push_back(v(C_CL,        8'hB0, 8'h00, 8'hB0, 3'd2, 0, 1));
        vecs.push_back(v(C_LD,        8'h33, 8'h00, 8'h33, 3'd2, 0, 1));
        vecs.push_back(v(C_RST|C_CL,  8'h77, 8'h00, 8'h00, 3'd0, 0, 0));
        vecs.push_back(v(C_RT,        8'h00, 8'h00, 8'h00, 3'd0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ctl, vecs[i].tgt, vecs[i].off);
            check_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].dep, vecs[i].ovf, vecs[i].unf);
        end

        // Randomized run against the reference model.
        model_step(C_RST, 8'h00, 8'h00);
        drive(C_RST, 8'h00, 8'h00);
        check_outputs("rnd_reset", m_pc, 3'(m_stk.size()), m_ovf, m_unf);
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ctl;
            logic [7:0] tgt, off;
            ctl[6] = ($urandom_range(0, 99) == 0);
            ctl[5] = ($urandom_range(0, 1) == 1);
            ctl[4] = ($urandom_range(0, 9) == 0);
            ctl[3] = ($urandom_range(0, 7) == 0);
            ctl[2] = ($urandom_range(0, 3) == 0);
            ctl[1] = ($urandom_range(0, 3) == 0);
            ctl[0] = ($urandom_range(0, 15) == 0);
            tgt = 8'($urandom);
            off = 8'($urandom);
            model_step(ctl, tgt, off);
            drive(ctl, tgt, off);
            check_outputs($sformatf("rnd%0d", i), m_pc, 3'(m_stk.size()), m_ovf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
